// File: rtl/comparator_pkg.sv
// comparator_pkg: result encodings and default counter width shared by the comparator slice
package comparator_pkg;
  localparam logic [2:0] RES_SMALLER = 3'b100;
  localparam logic [2:0] RES_EQUAL = 3'b010;
  localparam logic [2:0] RES_GREATER = 3'b001;
  localparam int CNT_W_DEFAULT = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_d, count_q;
  always_comb begin
    count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/comparator_1bit.sv
// comparator_1bit: registered 1-bit magnitude comparator with saturating per-result counters
module comparator_1bit
  import comparator_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input logic a,
  input logic b,
  input logic cnt_clr,
  output logic out_valid,
  output logic smaller,
  output logic equal,
  output logic greater,
  output logic [CNT_W-1:0] cnt_smaller,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_greater
);
  logic [2:0] res_d, res_q;
  logic out_valid_d, out_valid_q;
  always_comb begin
    res_d = !in_valid ? res_q : (a == b) ? RES_EQUAL : a ? RES_GREATER : RES_SMALLER;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q <= res_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign {smaller, equal, greater} = res_q;
  assign out_valid = out_valid_q;
  sat_counter #(.W(CNT_W)) u_cnt_smaller (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(in_valid & res_d[2]), .count(cnt_smaller)
  );
  sat_counter #(.W(CNT_W)) u_cnt_equal (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(in_valid & res_d[1]), .count(cnt_equal)
  );
  sat_counter #(.W(CNT_W)) u_cnt_greater (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(in_valid & res_d[0]), .count(cnt_greater)
  );
endmodule

// File: tb/tb_comparator_1bit.sv
// tb_comparator_1bit: vector table, corner sequences and randomized model check of comparator_1bit
module tb_comparator_1bit;
  logic clk = 1'b0;
  logic rst_n, in_valid, a, b, cnt_clr;
  logic out_valid, smaller, equal, greater;
  logic out_valid2, smaller2, equal2, greater2;
  logic [7:0] cnt_s, cnt_e, cnt_g;
  logic [1:0] cnt_s2, cnt_e2, cnt_g2;
  int checks = 0;
  int errors = 0;
  bit mv, ms, me, mg;
  int cs, ce, cg;
  typedef struct {
    bit rn, v, a, b, clr;
    bit ov, s, e, g;
    int cs, ce, cg;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  comparator_1bit #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .smaller(smaller), .equal(equal), .greater(greater),
    .cnt_smaller(cnt_s), .cnt_equal(cnt_e), .cnt_greater(cnt_g)
  );
  comparator_1bit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(out_valid2), .smaller(smaller2), .equal(equal2), .greater(greater2),
    .cnt_smaller(cnt_s2), .cnt_equal(cnt_e2), .cnt_greater(cnt_g2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  task automatic compare_model();
    check("ov", out_valid, mv);
    check("flags", {smaller, equal, greater}, {ms, me, mg});
    check("cnt_s", cnt_s, sat(cs, 8));
    check("cnt_e", cnt_e, sat(ce, 8));
    check("cnt_g", cnt_g, sat(cg, 8));
    check("ov2", out_valid2, mv);
    check("flags2", {smaller2, equal2, greater2}, {ms, me, mg});
    check("cnt_s2", cnt_s2, sat(cs, 2));
    check("cnt_e2", cnt_e2, sat(ce, 2));
    check("cnt_g2", cnt_g2, sat(cg, 2));
  endtask

  task automatic step(input bit rn, input bit v, input bit aa, input bit bb, input bit clr);
    rst_n = rn;
    in_valid = v;
    a = aa;
    b = bb;
    cnt_clr = clr;
    @(posedge clk);
    if (!rn) begin
      mv = 0; ms = 0; me = 0; mg = 0;
      cs = 0; ce = 0; cg = 0;
    end else begin
      mv = v;
      if (v) begin
        ms = int'(aa) < int'(bb);
        me = aa == bb;
        mg = int'(aa) > int'(bb);
      end
      if (clr) begin
        cs = 0; ce = 0; cg = 0;
      end else if (v) begin
        if (int'(aa) < int'(bb)) cs++;
        else if (aa == bb) ce++;
        else cg++;
      end
    end
    #1;
    compare_model();
  endtask

  initial begin
    rst_n = 0; in_valid = 0; a = 0; b = 0; cnt_clr = 0;
    mv = 0; ms = 0; me = 0; mg = 0; cs = 0; ce = 0; cg = 0;
    //          rn v a b clr  ov s e g  cs ce cg
    tbl[0]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1};
    tbl[4]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 2};
    tbl[5]  = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 2};
    tbl[6]  = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 2, 2};
    tbl[7]  = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 2, 2, 2};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 2, 2, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2, 2};
    tbl[10] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 2, 2, 2};
    tbl[11] = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    tbl[13] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rn, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].clr);
      check($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      check($sformatf("tbl%0d_flags", i), {smaller, equal, greater}, {tbl[i].s, tbl[i].e, tbl[i].g});
      check($sformatf("tbl%0d_cs", i), cnt_s, tbl[i].cs);
      check($sformatf("tbl%0d_ce", i), cnt_e, tbl[i].ce);
      check($sformatf("tbl%0d_cg", i), cnt_g, tbl[i].cg);
    end
    // saturation on the 2-bit instance: 1,2,3,3,3
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0);
      check($sformatf("sat%0d_cg2", i), cnt_g2, (i < 3) ? i + 1 : 3);
      check($sformatf("sat%0d_cg", i), cnt_g, i + 1);
    end
    // unknown operands while idle must not disturb held state
    step(1, 1, 0, 1, 0);
    rst_n = 1; in_valid = 0; a = 1'bx; b = 1'bx; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    mv = 0;
    compare_model();
    check("x_hold_smaller", smaller, 1'b1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(49) != 0, $urandom_range(3) != 0, 1'($urandom), 1'($urandom), $urandom_range(19) == 0);
    for (int i = 0; i < 1500; i++)
      step(1, $urandom_range(3) != 0, 1'($urandom), 1'($urandom), 0);
    check("sat8_reached", (cs > 255 || ce > 255 || cg > 255) ? 32'd1 : 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
